mult_share_scheduler: RTL and testbench

Round-robin scheduler that shares one sequential shift-add multiplier datapath among N_REQ requesters. It arbitrates pending requests, captures the winner's operands and sequences the datapath's flush, load, shift and add-shift controls. It returns the product to the granted requester with a one-cycle done pulse. It sits between requester blocks and a single shift-add datapath instance (multiplicand, multiplier and product registers).

---
 rtl/mult_share_scheduler_pkg.sv | 22 ++
 rtl/mult_share_scheduler_if.sv | 37 +++
 rtl/mult_share_scheduler_rr_arbiter.sv | 34 +++
 rtl/mult_share_scheduler.sv | 170 +++++++++++++++++
 tb/tb_mult_share_scheduler.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_share_scheduler_pkg.sv
// Shared types and constants for the shared shift-add multiplier scheduler.
package mult_sched_pkg;

  localparam int DEFAULT_L_WORD = 4;
  localparam int DEFAULT_N_REQ  = 4;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    LOAD,
    RUN,
    BYPASS
  } state_t;

  // A single requester still needs a one-bit pointer.
  function automatic int ptr_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  localparam int DEFAULT_PTR_W = ptr_width(DEFAULT_N_REQ);

endpackage

// File: rtl/mult_share_scheduler_if.sv
// Requester and datapath signals of the scheduler, grouped with master/slave views.
interface mult_share_scheduler_if
  import mult_sched_pkg::*;
#(
  parameter int N_REQ  = DEFAULT_N_REQ,
  parameter int L_WORD = DEFAULT_L_WORD
) ();

  logic [N_REQ-1:0]        req;
  logic [N_REQ*L_WORD-1:0] word1_bus;
  logic [N_REQ*L_WORD-1:0] word2_bus;
  logic [N_REQ-1:0]        ack;
  logic [N_REQ-1:0]        done;
  logic [2*L_WORD-1:0]     result;
  logic                    busy;
  logic [L_WORD-1:0]       dp_word1;
  logic [L_WORD-1:0]       dp_word2;
  logic                    dp_flush;
  logic                    dp_load_words;
  logic                    dp_shift;
  logic                    dp_add_shift;
  logic [L_WORD-1:0]       dp_multiplier;
  logic [2*L_WORD-1:0]     dp_product;

  modport slave (
    input  req, word1_bus, word2_bus, dp_multiplier, dp_product,
    output ack, done, result, busy, dp_word1, dp_word2,
           dp_flush, dp_load_words, dp_shift, dp_add_shift
  );

  modport master (
    output req, word1_bus, word2_bus, dp_multiplier, dp_product,
    input  ack, done, result, busy, dp_word1, dp_word2,
           dp_flush, dp_load_words, dp_shift, dp_add_shift
  );

endinterface

// File: rtl/mult_share_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester above the pointer, wrapping around.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  int               cand;
  logic [PTR_W-1:0] cand_idx;

  // The pointer itself is checked last so the previous winner has lowest priority.
  always_comb begin
    grant    = '0;
    idx      = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand     = (int'(ptr) + i) % N_REQ;
      cand_idx = PTR_W'(cand);
      if (!valid && req[cand_idx]) begin
        valid           = 1'b1;
        idx             = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_scheduler.sv
// Shares one shift-add multiplier datapath among N_REQ requesters, round-robin.
// Define MULT_SCHED_SHORTCUT_EN to answer multiplies by 1 without using the datapath.
module mult_share_scheduler
  import mult_sched_pkg::*;
#(
  parameter int N_REQ  = DEFAULT_N_REQ,
  parameter int L_WORD = DEFAULT_L_WORD
) (
  input logic                   clock,
  input logic                   reset,
  mult_share_scheduler_if.slave bus
);

  localparam int PTR_W  = ptr_width(N_REQ);
  localparam int P_WORD = 2 * L_WORD;

  state_t state, state_n;

  logic [PTR_W-1:0]  ptr, ptr_n;
  logic [L_WORD-1:0] op1, op1_n, op2, op2_n;
  logic [N_REQ-1:0]  ack_q, ack_n, done_q, done_n;
  logic [P_WORD-1:0] result_q, result_n;
  logic              busy_q, busy_n;
  logic              flush_q, flush_n, load_q, load_n;
  logic              shift_q, shift_n, add_q, add_n;

  logic [N_REQ-1:0]  grant;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_valid;
  logic [L_WORD-1:0] w1_arr [N_REQ];
  logic [L_WORD-1:0] w2_arr [N_REQ];
  logic [L_WORD-1:0] sel_w1, sel_w2;
  logic [L_WORD-1:0] next_mult;
  logic [N_REQ-1:0]  owner;

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign w1_arr[i] = bus.word1_bus[i*L_WORD +: L_WORD];
    assign w2_arr[i] = bus.word2_bus[i*L_WORD +: L_WORD];
  end

  assign sel_w1 = w1_arr[grant_idx];
  assign sel_w2 = w2_arr[grant_idx];
  assign owner  = N_REQ'(1) << ptr;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req   (bus.req),
    .ptr   (ptr),
    .grant (grant),
    .idx   (grant_idx),
    .valid (grant_valid)
  );

  // Controls are registered, so the next RUN control is chosen from the
  // multiplier value the datapath will hold after the current edge.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    op1_n     = op1;
    op2_n     = op2;
    ack_n     = '0;
    done_n    = '0;
    result_n  = result_q;
    busy_n    = busy_q;
    flush_n   = 1'b0;
    load_n    = 1'b0;
    shift_n   = 1'b0;
    add_n     = 1'b0;
    next_mult = '0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          ptr_n  = grant_idx;
          op1_n  = sel_w1;
          op2_n  = sel_w2;
          ack_n  = grant;
          busy_n = 1'b1;
          if (sel_w1 == '0 || sel_w2 == '0) begin
            state_n = FLUSH;
            flush_n = 1'b1;
          end
`ifdef MULT_SCHED_SHORTCUT_EN
          else if (sel_w1 == L_WORD'(1) || sel_w2 == L_WORD'(1)) begin
            state_n = BYPASS;
          end
`endif
          else begin
            state_n = LOAD;
            load_n  = 1'b1;
          end
        end
      end
      FLUSH: begin
        result_n = '0;
        done_n   = owner;
        busy_n   = 1'b0;
        state_n  = IDLE;
      end
      BYPASS: begin
        result_n = P_WORD'((op1 == L_WORD'(1)) ? op2 : op1);
        done_n   = owner;
        busy_n   = 1'b0;
        state_n  = IDLE;
      end
      LOAD: begin
        next_mult = op2;
        state_n   = RUN;
      end
      RUN: begin
        if (bus.dp_multiplier == '0) begin
          result_n = bus.dp_product;
          done_n   = owner;
          busy_n   = 1'b0;
          state_n  = IDLE;
        end else begin
          next_mult = (shift_q || add_q) ? (bus.dp_multiplier >> 1) : bus.dp_multiplier;
        end
      end
      default: state_n = IDLE;
    endcase
    if (next_mult != '0) begin
      add_n   = next_mult[0];
      shift_n = !next_mult[0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= PTR_W'(N_REQ - 1);
      op1      <= '0;
      op2      <= '0;
      ack_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      flush_q  <= 1'b0;
      load_q   <= 1'b0;
      shift_q  <= 1'b0;
      add_q    <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      op1      <= op1_n;
      op2      <= op2_n;
      ack_q    <= ack_n;
      done_q   <= done_n;
      result_q <= result_n;
      busy_q   <= busy_n;
      flush_q  <= flush_n;
      load_q   <= load_n;
      shift_q  <= shift_n;
      add_q    <= add_n;
    end
  end

  assign bus.ack           = ack_q;
  assign bus.done          = done_q;
  assign bus.result        = result_q;
  assign bus.busy          = busy_q;
  assign bus.dp_word1      = op1;
  assign bus.dp_word2      = op2;
  assign bus.dp_flush      = flush_q;
  assign bus.dp_load_words = load_q;
  assign bus.dp_shift      = shift_q;
  assign bus.dp_add_shift  = add_q;

endmodule

// File: tb/tb_mult_share_scheduler.sv
// Directed bench for mult_share_scheduler with a behavioural shift-add datapath.
module tb_mult_share_scheduler;

  localparam int N_REQ  = 4;
  localparam int L_WORD = 4;

  localparam logic [3:0] C_NONE  = 4'b0000;
  localparam logic [3:0] C_FLUSH = 4'b1000;
  localparam logic [3:0] C_LOAD  = 4'b0100;
  localparam logic [3:0] C_SHIFT = 4'b0010;
  localparam logic [3:0] C_ADD   = 4'b0001;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  mult_share_scheduler_if #(.N_REQ(N_REQ), .L_WORD(L_WORD)) bus ();

  mult_share_scheduler #(
    .N_REQ  (N_REQ),
    .L_WORD (L_WORD)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference shift-add datapath the scheduler steers.
  logic [2*L_WORD-1:0] mcand, prod;
  logic [L_WORD-1:0]   mplier;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
    end else if (bus.dp_flush) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
    end else if (bus.dp_load_words) begin
      mcand  <= {{L_WORD{1'b0}}, bus.dp_word1};
      mplier <= bus.dp_word2;
      prod   <= '0;
    end else if (bus.dp_shift) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end else if (bus.dp_add_shift) begin
      prod   <= prod + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  assign bus.dp_multiplier = mplier;
  assign bus.dp_product    = prod;

  logic [3:0] ctl;
  assign ctl = {bus.dp_flush, bus.dp_load_words, bus.dp_shift, bus.dp_add_shift};

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input int idx, input logic [L_WORD-1:0] w1, input logic [L_WORD-1:0] w2);
    bus.word1_bus[idx*L_WORD +: L_WORD] = w1;
    bus.word2_bus[idx*L_WORD +: L_WORD] = w2;
    bus.req[idx] = 1'b1;
  endtask

  task automatic drop(input int idx);
    bus.req[idx] = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_ack"}, 32'(bus.ack), 32'h0);
    check_output({tag, "_done"}, 32'(bus.done), 32'h0);
    check_output({tag, "_result"}, 32'(bus.result), 32'h0);
    check_output({tag, "_busy"}, 32'(bus.busy), 32'h0);
    check_output({tag, "_ctl"}, 32'(ctl), 32'h0);
    check_output({tag, "_w1"}, 32'(bus.dp_word1), 32'h0);
    check_output({tag, "_w2"}, 32'(bus.dp_word2), 32'h0);
  endtask

  task automatic wait_ack(input int budget);
    for (int t = 0; t < budget; t++) begin
      tick();
      if (bus.ack != '0) break;
    end
  endtask

  task automatic wait_done(input int budget);
    for (int t = 0; t < budget; t++) begin
      tick();
      if (bus.done != '0) break;
    end
  endtask

  logic [3:0] exp_oh;
  logic [3:0] seq [4];

  initial begin
    bus.req       = '0;
    bus.word1_bus = '0;
    bus.word2_bus = '0;

    $display("[TB] reset state");
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    $display("[TB] single request 5x6");
    apply_stimulus(0, 4'd5, 4'd6);
    tick();
    check_output("t1_ack", 32'(bus.ack), 32'h1);
    check_output("t1_c1", 32'(ctl), 32'(C_LOAD));
    check_output("t1_busy1", 32'(bus.busy), 32'h1);
    check_output("t1_w1", 32'(bus.dp_word1), 32'd5);
    check_output("t1_w2", 32'(bus.dp_word2), 32'd6);
    drop(0);
    tick();
    check_output("t1_c2", 32'(ctl), 32'(C_SHIFT));
    tick();
    check_output("t1_c3", 32'(ctl), 32'(C_ADD));
    tick();
    check_output("t1_c4", 32'(ctl), 32'(C_ADD));
    tick();
    check_output("t1_c5", 32'(ctl), 32'(C_NONE));
    check_output("t1_done5", 32'(bus.done), 32'h0);
    tick();
    check_output("t1_done6", 32'(bus.done), 32'h1);
    check_output("t1_result", 32'(bus.result), 32'd30);
    check_output("t1_busy6", 32'(bus.busy), 32'h0);
    tick();
    check_output("t1_done7", 32'(bus.done), 32'h0);
    check_output("t1_hold", 32'(bus.result), 32'd30);

    $display("[TB] empty operand 0x9");
    apply_stimulus(2, 4'd0, 4'd9);
    tick();
    check_output("t2_ack", 32'(bus.ack), 32'h4);
    check_output("t2_c1", 32'(ctl), 32'(C_FLUSH));
    drop(2);
    tick();
    check_output("t2_done", 32'(bus.done), 32'h4);
    check_output("t2_result", 32'(bus.result), 32'h0);
    check_output("t2_c2", 32'(ctl), 32'(C_NONE));
    tick();
    check_output("t2_c3", 32'(ctl), 32'(C_NONE));
    check_output("t2_busy3", 32'(bus.busy), 32'h0);

    $display("[TB] fairness between requesters 0 and 1");
    apply_stimulus(0, 4'd3, 4'd3);
    apply_stimulus(1, 4'd3, 4'd3);
    for (int j = 0; j < 4; j++) begin
      exp_oh = 4'(1 << (j % 2));
      wait_ack(12);
      check_output("t3_ack", 32'(bus.ack), 32'(exp_oh));
      if (j == 3) begin
        drop(0);
        drop(1);
      end
      wait_done(12);
      check_output("t3_done", 32'(bus.done), 32'(exp_oh));
      check_output("t3_result", 32'(bus.result), 32'd9);
    end

    $display("[TB] reset during RUN");
    apply_stimulus(2, 4'd7, 4'd5);
    tick();
    check_output("t4_ack", 32'(bus.ack), 32'h4);
    drop(2);
    tick();
    tick();
    check_output("t4_busy", 32'(bus.busy), 32'h1);
    reset = 1'b1;
    #1;
    check_all_zero("t4_rst");
    apply_stimulus(3, 4'd4, 4'd2);
    apply_stimulus(0, 4'd2, 4'd3);
    tick();
    check_output("t4_rst_done", 32'(bus.done), 32'h0);
    check_output("t4_rst_ack", 32'(bus.ack), 32'h0);
    reset = 1'b0;
    wait_ack(4);
    check_output("t4_ack0", 32'(bus.ack), 32'h1);
    check_output("t4_nodone", 32'(bus.done), 32'h0);
    drop(0);
    wait_done(12);
    check_output("t4_done0", 32'(bus.done), 32'h1);
    check_output("t4_result0", 32'(bus.result), 32'd6);
    wait_ack(4);
    check_output("t4_ack3", 32'(bus.ack), 32'h8);
    drop(3);
    wait_done(12);
    check_output("t4_done3", 32'(bus.done), 32'h8);
    check_output("t4_result3", 32'(bus.result), 32'd8);

    $display("[TB] fairness with all four requesters");
    reset = 1'b1;
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) apply_stimulus(i, 4'd3, 4'd3);
    for (int j = 0; j < 5; j++) begin
      exp_oh = 4'(1 << (j % 4));
      wait_ack(12);
      check_output("t5_ack", 32'(bus.ack), 32'(exp_oh));
      if (j == 4) bus.req = '0;
      wait_done(12);
      check_output("t5_done", 32'(bus.done), 32'(exp_oh));
      check_output("t5_result", 32'(bus.result), 32'd9);
    end

    $display("[TB] maximum operands 15x15");
    apply_stimulus(1, 4'd15, 4'd15);
    tick();
    check_output("t6_ack", 32'(bus.ack), 32'h2);
    check_output("t6_c1", 32'(ctl), 32'(C_LOAD));
    drop(1);
    for (int c = 2; c <= 5; c++) begin
      tick();
      check_output("t6_run", 32'(ctl), 32'(C_ADD));
    end
    tick();
    check_output("t6_c6", 32'(ctl), 32'(C_NONE));
    check_output("t6_busy6", 32'(bus.busy), 32'h1);
    check_output("t6_done6", 32'(bus.done), 32'h0);
    tick();
    check_output("t6_done7", 32'(bus.done), 32'h2);
    check_output("t6_result", 32'(bus.result), 32'd225);

    $display("[TB] operand of one 1x13");
    apply_stimulus(2, 4'd1, 4'd13);
    tick();
    check_output("t7_ack", 32'(bus.ack), 32'h4);
`ifdef MULT_SCHED_SHORTCUT_EN
    check_output("t7_c1", 32'(ctl), 32'(C_NONE));
    drop(2);
    tick();
    check_output("t7_c2", 32'(ctl), 32'(C_NONE));
    check_output("t7_done2", 32'(bus.done), 32'h4);
    check_output("t7_result", 32'(bus.result), 32'd13);
`else
    check_output("t7_c1", 32'(ctl), 32'(C_LOAD));
    drop(2);
    seq[0] = C_ADD;
    seq[1] = C_SHIFT;
    seq[2] = C_ADD;
    seq[3] = C_ADD;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_output("t7_run", 32'(ctl), 32'(seq[c]));
    end
    tick();
    check_output("t7_done6", 32'(bus.done), 32'h0);
    tick();
    check_output("t7_done7", 32'(bus.done), 32'h4);
    check_output("t7_result", 32'(bus.result), 32'd13);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
